// File: rtl/sigma_arith_pkg.sv
// Shared arithmetic definitions for the multiplier/divider pair:
// default operand width and the one-hot phase encoding.
package sigma_arith_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [2:0] PH1 = 3'b001;
  localparam logic [2:0] PH2 = 3'b010;
  localparam logic [2:0] PH3 = 3'b100;

  typedef enum logic [2:0] {
    IDLE = PH1,
    ITER = PH2,
    FIX  = PH3
  } phase_e;

endpackage

// File: rtl/divider_if.sv
// Start/done handshake and operand/result bus of the divider.
// Vectors are MSB-first: bit 0 is the most significant bit.
interface divider_if
  import sigma_arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic                 start;
  logic [0:2*WIDTH-1]   dividend;
  logic [0:WIDTH-1]     divisor;
  logic [0:WIDTH-1]     quotient;
  logic [0:WIDTH-1]     remainder;
  logic                 overflow;
  logic                 done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, overflow, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, overflow, done
  );

endinterface

// File: rtl/divider_addsub.sv
// (WIDTH+1)-bit add/subtract of the divisor for one non-restoring step.
// Carry out is dropped; the true result always fits the signed range.
module divider_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   operand,
  input  logic [WIDTH-1:0] divisor,
  input  logic             subtract,
  output logic [WIDTH:0]   result
);

  always_comb begin
    if (subtract)
      result = operand - {1'b0, divisor};
    else
      result = operand + {1'b0, divisor};
  end

endmodule

// File: rtl/divider.sv
// Unsigned 2W/W non-restoring divider, one quotient bit per clock,
// start/done handshake shared with the bit-pair multiplier.
module divider
  import sigma_arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic     clock,
  input  logic     reset,
  divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  phase_e            state;
  logic [CW-1:0]     count;
  logic [WIDTH:0]    a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  dvs;
  logic              ovf;
  logic [WIDTH-1:0]  quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic              overflow_q;
  logic              done_q;

  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH:0]    sh;
  logic [WIDTH:0]    sum;

  // Ascending port slices map leftmost-to-leftmost, so MSB-first order is kept.
  always_comb begin
    hi = bus.dividend[0:WIDTH-1];
    lo = bus.dividend[WIDTH:2*WIDTH-1];
    sh = {a[WIDTH-1:0], b[WIDTH-1]};
  end

  divider_addsub #(.WIDTH(WIDTH)) u_addsub (
    .operand  (sh),
    .divisor  (dvs),
    .subtract (~a[WIDTH]),
    .result   (sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      a           <= '0;
      b           <= '0;
      dvs         <= '0;
      ovf         <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            done_q <= 1'b0;
            dvs    <= bus.divisor;
            if (bus.divisor == '0 || hi >= bus.divisor) begin
              ovf   <= 1'b1;
              state <= FIX;
            end else begin
              ovf   <= 1'b0;
              a     <= {1'b0, hi};
              b     <= lo;
              count <= CW'(WIDTH - 1);
              state <= ITER;
            end
          end
        end
        ITER: begin
          // Low dividend bits shift out of b's top as quotient bits enter its bottom.
          a     <= sum;
          b     <= {b[WIDTH-2:0], ~sum[WIDTH]};
          count <= count - CW'(1);
          if (count == '0)
            state <= FIX;
        end
        FIX: begin
          if (ovf) begin
            quotient_q  <= '1;
            remainder_q <= '0;
            overflow_q  <= 1'b1;
          end else begin
            quotient_q  <= b;
            remainder_q <= a[WIDTH] ? (a[WIDTH-1:0] + dvs) : a[WIDTH-1:0];
            overflow_q  <= 1'b0;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.overflow  = overflow_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the driver queues expected results,
// the monitor pops one on each rising done edge.
module tb_divider;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    int unsigned  lat;
  } exp_t;

  logic clock;
  logic reset;

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor
  bit          prev_done = 1'b1;
  int unsigned low_cnt   = 0;
  exp_t        got_e;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        low_cnt   = 0;
        prev_done = bus.done;
      end else begin
        if (!bus.done) begin
          low_cnt++;
        end else if (!prev_done) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got done with empty queue expected none");
          end else begin
            got_e = sb.pop_front();
            check("quotient",  64'(bus.quotient),  64'(got_e.q));
            check("remainder", 64'(bus.remainder), 64'(got_e.r));
            check("overflow",  64'(bus.overflow),  64'(got_e.ovf));
            check("latency",   64'(low_cnt),       64'(got_e.lat));
          end
          low_cnt = 0;
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && !bus.done; i++) begin
      @(posedge clock);
      #1;
    end
    if (!bus.done) begin
      n_total++;
      $display("FAIL idle_timeout: got done=0 expected done=1 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [63:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic eovf);
    exp_t e;
    wait_idle();
    e.q   = eq;
    e.r   = er;
    e.ovf = eovf;
    e.lat = eovf ? 1 : W + 1;
    sb.push_back(e);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  logic [63:0]  rdd;
  logic [W-1:0] rdv;
  logic [W-1:0] rhi;
  logic [63:0]  rq;

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_done",      64'(bus.done),      64'd1);
    check("rst_quotient",  64'(bus.quotient),  64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_overflow",  64'(bus.overflow),  64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    issue(64'h00001234_56789ABC, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue(64'h00000005_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue(64'h00000006_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue(64'h00000004_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0);
    issue(64'd0, 32'd9, 32'd0, 32'd0, 1'b0);
    issue(64'd1, 32'd1, 32'd1, 32'd0, 1'b0);
    issue(64'd3549895, 32'd113, 32'd31415, 32'd0, 1'b0);

    // Reset in the middle of an operation: no result may appear for it.
    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    check("midrst_done",      64'(bus.done),      64'd1);
    check("midrst_quotient",  64'(bus.quotient),  64'd0);
    check("midrst_remainder", 64'(bus.remainder), 64'd0);
    check("midrst_overflow",  64'(bus.overflow),  64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Start pulsed and inputs changed while busy: ignored.
    issue(64'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 64'd999;
    bus.divisor  = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      rdv = $urandom;
      if (rdv == '0) rdv = 32'd1;
      rhi = $urandom % rdv;
      rdd = {rhi, 32'($urandom)};
      rq  = rdd / {32'd0, rdv};
      issue(rdd, rdv, rq[W-1:0], W'(rdd % {32'd0, rdv}), 1'b0);
    end

    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
